// File: rtl/fft_frame_sequencer.sv
// Buffers ADC samples in a FIFO and streams them to a streaming FFT core in
// FRAME_LEN-sample frames, then waits for the core's output frame before the next.
module fft_frame_sequencer #(
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic [23:0] sample_in,
  input  logic        sample_valid,
  input  logic        sink_ready,
  output logic        sink_valid,
  output logic        sink_sop,
  output logic        sink_eop,
  output logic [23:0] sink_real,
  output logic [23:0] sink_imag,
  input  logic        source_valid,
  input  logic        source_sop,
  input  logic        source_eop,
  input  logic [1:0]  source_error,
  output logic        frame_done,
  output logic        overflow,
  output logic        fft_error,
  output logic [15:0] frame_count
);

  localparam int unsigned DW   = 24;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(FRAME_LEN);
  localparam logic [CW-1:0]   LAST     = CW'(FRAME_LEN - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_OUT} state_t;

  // Reset asserts immediately, deasserts after two MCLK edges
  logic rst_meta_q, rst_sync_q, rst_n;
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end
  assign rst_n = rst_sync_q;

  logic [DW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] fifo_cnt_q, fifo_cnt_d;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, out_cnt_q, out_cnt_d;
  logic            sink_valid_q, sink_valid_d, sink_sop_q, sink_sop_d, sink_eop_q, sink_eop_d;
  logic [DW-1:0]   sink_real_q, sink_real_d, head_d;
  logic            frame_done_q, frame_done_d, overflow_q, overflow_d, fft_error_q, fft_error_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic            fifo_full, xfer, wr_en;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    out_cnt_d     = out_cnt_q;
    overflow_d    = overflow_q;
    fft_error_d   = fft_error_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    sink_valid_d  = 1'b0;
    sink_sop_d    = 1'b0;
    sink_eop_d    = 1'b0;
    sink_real_d   = '0;

    fifo_full  = (fifo_cnt_q == FULL_CNT);
    xfer       = sink_valid_q && sink_ready;
    wr_en      = sample_valid && (!fifo_full || xfer);
    wr_ptr_d   = wr_ptr_q + AW'(wr_en);
    rd_ptr_d   = rd_ptr_q + AW'(xfer);
    fifo_cnt_d = fifo_cnt_q + CNTW'(wr_en) - CNTW'(xfer);
    // Head after this cycle's update; a write into an emptying FIFO becomes the head
    head_d     = (fifo_cnt_q == CNTW'(xfer)) ? sample_in : mem_q[rd_ptr_d];

    if (sample_valid && !wr_en) overflow_d = 1'b1;
    if (source_valid && (source_error != 2'b00)) fft_error_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (fifo_cnt_q != '0) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        out_cnt_d = '0;
        if (xfer) cnt_d = cnt_q + CW'(1);
        if (xfer && (cnt_q == LAST)) begin
          state_d = WAIT_OUT;
        end else if (fifo_cnt_d != '0) begin
          sink_valid_d = 1'b1;
          sink_real_d  = head_d;
          sink_sop_d   = (cnt_d == '0);
          sink_eop_d   = (cnt_d == LAST);
        end
      end
      WAIT_OUT: begin
        if (source_valid) begin
          out_cnt_d = out_cnt_q + CW'(1);
          if ((source_sop && (out_cnt_q != '0)) || (source_eop && (out_cnt_q != LAST)))
            fft_error_d = 1'b1;
          if (source_eop) begin
            state_d       = IDLE;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= sample_in;
  end

  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      cnt_q         <= '0;
      out_cnt_q     <= '0;
      sink_valid_q  <= 1'b0;
      sink_sop_q    <= 1'b0;
      sink_eop_q    <= 1'b0;
      sink_real_q   <= '0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      fft_error_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      cnt_q         <= cnt_d;
      out_cnt_q     <= out_cnt_d;
      sink_valid_q  <= sink_valid_d;
      sink_sop_q    <= sink_sop_d;
      sink_eop_q    <= sink_eop_d;
      sink_real_q   <= sink_real_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
      fft_error_q   <= fft_error_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign sink_valid  = sink_valid_q;
  assign sink_sop    = sink_sop_q;
  assign sink_eop    = sink_eop_q;
  assign sink_real   = sink_real_q;
  assign sink_imag   = '0;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign fft_error   = fft_error_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized bench for fft_frame_sequencer: sample queue scoreboard plus a
// behavioural FFT core that echoes one output frame per input frame.
module tb_fft_frame_sequencer;
  localparam int unsigned FL = 1024;
  localparam int unsigned FD = 16;

  logic        MCLK = 1'b0;
  logic        reset;
  logic [23:0] sample_in;
  logic        sample_valid, sink_ready;
  logic        sink_valid, sink_sop, sink_eop;
  logic [23:0] sink_real, sink_imag;
  logic        source_valid, source_sop, source_eop;
  logic [1:0]  source_error;
  logic        frame_done, overflow, fft_error;
  logic [15:0] frame_count;

  fft_frame_sequencer #(.FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .MCLK(MCLK), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sink_ready(sink_ready), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .source_valid(source_valid),
    .source_sop(source_sop), .source_eop(source_eop), .source_error(source_error),
    .frame_done(frame_done), .overflow(overflow), .fft_error(fft_error), .frame_count(frame_count)
  );

  always #10 MCLK = ~MCLK;

  int tests = 0, fails = 0;
  int fed, xfer, target, frame_pos, stall_pct, feed_pct, ramp;
  int n_done, n_val, n_flag, n_stab, n_late, n_imag;
  int out_state, out_beat, out_len, err_beat, out_delay;
  logic [23:0] exp_q[$];
  logic [23:0] p_real, sop_val, eop_val, first_val;
  logic        p_valid, p_ready, p_sop, p_eop, eop_prev;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock of stimulus: observe outputs, score transfers, drive ADC and FFT model
  task automatic tick();
    logic [23:0] v;
    if (p_valid && !p_ready &&
        (sink_valid !== 1'b1 || sink_real !== p_real || sink_sop !== p_sop || sink_eop !== p_eop))
      n_stab++;
    if (eop_prev && frame_done !== 1'b1) n_late++;
    if (frame_done === 1'b1) n_done++;
    if (sink_imag !== 24'd0) n_imag++;

    sink_ready = (int'($urandom_range(99)) >= stall_pct);
    sample_valid = 1'b0;
    if (fed < target && (fed - xfer) < 12 && int'($urandom_range(99)) < feed_pct) begin
      v = ramp != 0 ? 24'(fed % FL) : 24'($urandom);
      if (fed == 0) first_val = v;
      sample_valid = 1'b1;
      sample_in = v;
      exp_q.push_back(v);
      fed++;
    end

    if (sink_valid === 1'b1 && sink_ready) begin
      if (exp_q.size() == 0) n_val++;
      else begin
        v = exp_q.pop_front();
        if (sink_real !== v) n_val++;
      end
      if (sink_sop !== (frame_pos == 0) || sink_eop !== (frame_pos == FL - 1)) n_flag++;
      if (sink_sop === 1'b1) sop_val = sink_real;
      if (sink_eop === 1'b1) eop_val = sink_real;
      if (frame_pos == FL - 1) begin
        frame_pos = 0;
        out_state = 1;
        out_delay = 3;
      end else frame_pos++;
      xfer++;
    end

    eop_prev = 1'b0;
    source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0; source_error = 2'b00;
    if (out_state == 1) begin
      if (out_delay == 0) out_state = 2;
      else out_delay--;
    end else if (out_state == 2 && $urandom_range(9) < 8) begin
      source_valid = 1'b1;
      source_sop = (out_beat == 0);
      source_eop = (out_beat == out_len - 1);
      if (out_beat == err_beat) source_error = 2'b01;
      if (source_eop) begin
        out_state = 0;
        out_beat = 0;
        eop_prev = 1'b1;
      end else out_beat++;
    end

    p_valid = sink_valid; p_ready = sink_ready; p_real = sink_real;
    p_sop = sink_sop; p_eop = sink_eop;
    @(posedge MCLK); #1;
  endtask

  task automatic run_frames(input int n);
    int goal = n_done + n;
    int budget = 0;
    target += n * FL;
    while (n_done < goal && budget < 20000 * n) begin
      tick();
      budget++;
    end
    repeat (20) tick();
  endtask

  task automatic run_xfers(input int n);
    int goal = xfer + n;
    int budget = 0;
    target = fed + FL;
    while (xfer < goal && budget < 20000) begin
      tick();
      budget++;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    sample_valid = 1'b0; sample_in = '0; sink_ready = 1'b0;
    source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0; source_error = 2'b00;
    repeat (3) @(posedge MCLK);
    #1 reset = 1'b1;
    repeat (3) @(posedge MCLK);
    #1;
    fed = 0; xfer = 0; target = 0; frame_pos = 0; exp_q.delete();
    n_done = 0; n_val = 0; n_flag = 0; n_stab = 0; n_late = 0; n_imag = 0;
    out_state = 0; out_beat = 0; out_len = FL; err_beat = -1;
    p_valid = 1'b0; p_ready = 1'b0; eop_prev = 1'b0;
    ramp = 0; stall_pct = 0; feed_pct = 60;
    sop_val = 'x; eop_val = 'x; first_val = 'x;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sample_valid = 1'b0; sample_in = '0; sink_ready = 1'b0;
    source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0; source_error = 2'b00;
    #2 reset = 1'b0;
    #3;
    tests++;
    if ({sink_valid, sink_sop, sink_eop, sink_real, sink_imag, frame_done, overflow, fft_error, frame_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got valid=%b sop=%b eop=%b real=%h done=%b ovf=%b err=%b cnt=%0d exp all 0",
               sink_valid, sink_sop, sink_eop, sink_real, frame_done, overflow, fft_error, frame_count);
    end
  endtask

  task automatic test_latency();
    reset_dut();
    sink_ready = 1'b1;
    sample_valid = 1'b1; sample_in = 24'hABCDEF;
    @(posedge MCLK); #1;
    sample_valid = 1'b0;
    tests++; if (sink_valid !== 1'b0) begin fails++; $display("FAIL latency_c1 got=%b exp=0", sink_valid); end
    @(posedge MCLK); #1;
    tests++; if (sink_valid !== 1'b0) begin fails++; $display("FAIL latency_c2 got=%b exp=0", sink_valid); end
    sink_ready = 1'b0;
    @(posedge MCLK); #1;
    tests++;
    if (sink_valid !== 1'b1 || sink_real !== 24'hABCDEF || sink_sop !== 1'b1) begin
      fails++;
      $display("FAIL latency_c3 got valid=%b real=%h sop=%b exp 1/abcdef/1", sink_valid, sink_real, sink_sop);
    end
  endtask

  task automatic test_ramp();
    reset_dut();
    ramp = 1; stall_pct = 0; feed_pct = 100;
    run_frames(1);
    tests++; if (xfer !== 1024) begin fails++; $display("FAIL ramp_xfers got=%0d exp=1024", xfer); end
    tests++; if (n_val !== 0 || n_flag !== 0) begin fails++; $display("FAIL ramp_data got val_err=%0d flag_err=%0d exp 0", n_val, n_flag); end
    tests++; if (sop_val !== 24'd0 || eop_val !== 24'd1023) begin fails++; $display("FAIL ramp_markers got sop=%0d eop=%0d exp 0/1023", sop_val, eop_val); end
    tests++; if (n_done !== 1 || frame_count !== 16'd1) begin fails++; $display("FAIL ramp_done got pulses=%0d count=%0d exp 1/1", n_done, frame_count); end
    tests++; if (n_late !== 0 || n_imag !== 0) begin fails++; $display("FAIL ramp_misc got late=%0d imag=%0d exp 0", n_late, n_imag); end
  endtask

  task automatic test_stall();
    reset_dut();
    stall_pct = 30; feed_pct = 60;
    run_frames(3);
    tests++; if (xfer !== 3072) begin fails++; $display("FAIL stall_xfers got=%0d exp=3072", xfer); end
    tests++; if (n_val !== 0 || n_flag !== 0) begin fails++; $display("FAIL stall_data got val_err=%0d flag_err=%0d exp 0", n_val, n_flag); end
    tests++; if (n_stab !== 0) begin fails++; $display("FAIL stall_stable got violations=%0d exp 0", n_stab); end
    tests++; if (n_done !== 3 || frame_count !== 16'd3) begin fails++; $display("FAIL stall_done got pulses=%0d count=%0d exp 3/3", n_done, frame_count); end
    tests++; if (overflow !== 1'b0 || fft_error !== 1'b0) begin fails++; $display("FAIL stall_flags got ovf=%b err=%b exp 0/0", overflow, fft_error); end
  endtask

  task automatic test_full_rw();
    int got = 0, bad = 0;
    reset_dut();
    for (int k = 0; k < 16; k++) begin
      sample_valid = 1'b1; sample_in = 24'h200000 + 24'(k);
      @(posedge MCLK); #1;
    end
    sample_valid = 1'b0;
    tests++; if (sink_valid !== 1'b1 || sink_real !== 24'h200000) begin fails++; $display("FAIL full_head got valid=%b real=%h exp 1/200000", sink_valid, sink_real); end
    sink_ready = 1'b1; sample_valid = 1'b1; sample_in = 24'h200010;
    @(posedge MCLK); #1;
    sample_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (sink_valid === 1'b1) begin
        if (sink_real !== 24'h200001 + 24'(got)) bad++;
        got++;
      end
      @(posedge MCLK); #1;
    end
    tests++; if (got !== 16 || bad !== 0) begin fails++; $display("FAIL full_rw_drain got count=%0d bad=%0d exp 16/0", got, bad); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_rw_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    int got = 0, bad = 0, seen17 = 0;
    reset_dut();
    for (int k = 0; k < 17; k++) begin
      sample_valid = 1'b1; sample_in = 24'h300000 + 24'(k);
      @(posedge MCLK); #1;
    end
    sample_valid = 1'b0;
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    tests++; if (sink_valid !== 1'b1 || sink_real !== 24'h300000 || sink_sop !== 1'b1) begin fails++; $display("FAIL ovf_head got valid=%b real=%h sop=%b exp 1/300000/1", sink_valid, sink_real, sink_sop); end
    sink_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (sink_valid === 1'b1) begin
        if (sink_real === 24'h300010) seen17++;
        if (sink_real !== 24'h300000 + 24'(got)) bad++;
        got++;
      end
      @(posedge MCLK); #1;
    end
    tests++; if (got !== 16 || bad !== 0 || seen17 !== 0) begin fails++; $display("FAIL ovf_drain got count=%0d bad=%0d dropped_seen=%0d exp 16/0/0", got, bad, seen17); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_reset_midframe();
    reset_dut();
    stall_pct = 20; feed_pct = 60;
    run_xfers(500);
    #4 reset = 1'b0;
    sample_valid = 1'b0; sink_ready = 1'b0;
    #1;
    tests++; if ({sink_valid, sink_sop, sink_eop, sink_real, frame_done, frame_count} !== '0) begin fails++; $display("FAIL midreset_async got valid=%b real=%h cnt=%0d exp 0", sink_valid, sink_real, frame_count); end
    repeat (2) @(posedge MCLK);
    #1;
    tests++; if ({sink_valid, sink_sop, sink_eop, sink_real, frame_done, overflow, fft_error} !== '0) begin fails++; $display("FAIL midreset_hold got valid=%b real=%h exp 0", sink_valid, sink_real); end
    reset_dut();
    stall_pct = 20; feed_pct = 60;
    run_frames(1);
    tests++; if (sop_val !== first_val || n_val !== 0 || n_flag !== 0) begin fails++; $display("FAIL midreset_sop got sop=%h first=%h val_err=%0d flag_err=%0d", sop_val, first_val, n_val, n_flag); end
    tests++; if (n_done !== 1 || frame_count !== 16'd1) begin fails++; $display("FAIL midreset_done got pulses=%0d count=%0d exp 1/1", n_done, frame_count); end
  endtask

  task automatic test_source_error();
    reset_dut();
    stall_pct = 10; err_beat = 100;
    run_frames(1);
    tests++; if (fft_error !== 1'b1 || n_done !== 1 || frame_count !== 16'd1) begin fails++; $display("FAIL srcerr_set got err=%b pulses=%0d count=%0d exp 1/1/1", fft_error, n_done, frame_count); end
    err_beat = -1;
    run_frames(1);
    tests++; if (fft_error !== 1'b1 || n_done !== 2 || n_val !== 0) begin fails++; $display("FAIL srcerr_sticky got err=%b pulses=%0d val_err=%0d exp 1/2/0", fft_error, n_done, n_val); end
  endtask

  task automatic test_short_frame();
    reset_dut();
    stall_pct = 10;
    tests++; if (fft_error !== 1'b0) begin fails++; $display("FAIL short_pre got err=%b exp=0", fft_error); end
    out_len = 1000;
    run_frames(1);
    tests++; if (fft_error !== 1'b1 || n_done !== 1) begin fails++; $display("FAIL short_err got err=%b pulses=%0d exp 1/1", fft_error, n_done); end
    out_len = FL;
    run_frames(1);
    tests++; if (xfer !== 2048 || n_val !== 0 || n_flag !== 0) begin fails++; $display("FAIL short_next got xfers=%0d val_err=%0d flag_err=%0d exp 2048/0/0", xfer, n_val, n_flag); end
    tests++; if (n_done !== 2 || frame_count !== 16'd2 || n_late !== 0) begin fails++; $display("FAIL short_done got pulses=%0d count=%0d late=%0d exp 2/2/0", n_done, frame_count, n_late); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ramp();
    test_stall();
    test_full_rw();
    test_overflow();
    test_reset_midframe();
    test_source_error();
    test_short_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 Parameter FRAME_LEN, default 1024, samples per FFT frame (power of 2, 8..4096).
REQ-002 Parameter FIFO_DEPTH, default 16, input sample buffer entries (power of 2, >=4).
REQ-003 MCLK  in  1  single 50 MHz clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 sample_in  in  24  signed audio sample from the ADC path.
REQ-006 sample_valid  in  1  one-cycle strobe per sample (nominally every ~1042 MCLKs).
REQ-007 sink_ready  in  1  FFT core ready to accept input.
REQ-008 sink_valid  out  1  sample presented to the FFT core.
REQ-009 sink_sop / sink_eop  out  1 each  frame start and end markers to the FFT core.
REQ-010 sink_real  out  24  sample to the FFT core.
REQ-011 sink_imag  out  24  constant zero to the FFT core.
REQ-012 source_valid / source_sop / source_eop  in  1 each  FFT core output framing.
REQ-013 source_error  in  2  FFT core error code.
REQ-014 frame_done  out  1  one-cycle pulse when an FFT output frame completes.
REQ-015 overflow  out  1  sticky flag: a sample was dropped.
REQ-016 fft_error  out  1  sticky flag: source_error was nonzero.
REQ-017 frame_count  out  16  completed output frames, wraps modulo 2^16.

Function
REQ-018 Each sample_valid pulse SHALL write sample_in to the FIFO; if the FIFO is full, the sample is dropped, overflow is set, and FIFO contents are unchanged.
REQ-019 A simultaneous FIFO write and read when full SHALL be accepted (no drop), because the read frees an entry in the same cycle.
REQ-020 The FSM SHALL have states IDLE, STREAM and WAIT_OUT; reset enters IDLE.
REQ-021 IDLE -> STREAM when the FIFO is non-empty; the sample counter is cleared on entry.
REQ-022 In STREAM, sink_valid SHALL equal "FIFO non-empty"; sink_real is the FIFO head, registered so there are no combinational paths from inputs to sink_*.
REQ-023 A transfer SHALL occur on any cycle with sink_valid=1 and sink_ready=1: the FIFO pops and the sample counter increments.
REQ-024 While sink_ready=0, sink_valid, sink_real, sink_sop and sink_eop SHALL hold stable.
REQ-025 sink_sop=1 only while counter=0; sink_eop=1 only while counter=FRAME_LEN-1; both are qualified by sink_valid.
REQ-026 The transfer at counter=FRAME_LEN-1 SHALL move the FSM to WAIT_OUT with sink_valid=0 on the next cycle.
REQ-027 In WAIT_OUT, no sink transfers SHALL occur and the FIFO continues to accept writes.
REQ-028 WAIT_OUT -> IDLE on the cycle source_valid=1 and source_eop=1; frame_done pulses one cycle later and frame_count increments.
REQ-029 An output count mismatch SHALL be detected: source_eop while the output beat counter is not FRAME_LEN-1, or source_sop while the counter is not 0, sets fft_error; the FSM still returns to IDLE on source_eop.
REQ-030 source_error != 0 with source_valid=1 SHALL set fft_error; sequencing is otherwise unaffected.
REQ-031 Latency from the first FIFO write in IDLE to sink_valid=1 SHALL be 2 cycles.
REQ-032 source_* inputs SHALL be ignored outside WAIT_OUT, except source_error, which is monitored in all states.

Reset
REQ-033 With reset=0, all outputs SHALL be 0, the FIFO empty, counters 0, the sticky flags cleared, and the state IDLE, immediately and asynchronously.
REQ-034 reset asserted mid-frame SHALL discard the partial frame; after release, the next frame starts with sink_sop on the first new sample.
REQ-035 Deassertion SHALL be synchronised inside the block with a 2-flop synchroniser before it reaches the FSM.

Verification
REQ-036 FRAME_LEN=1024 ramp 0..1023, sink_ready=1, FFT model echoes the frame -> exactly 1024 transfers, sop with value 0, eop with value 1023, one frame_done, frame_count=1.
REQ-037 Random sink_ready at 30% low for 3 frames -> sink_* stable while stalled, no loss, 3072 transfers in order, frame_count=3.
REQ-038 FIFO_DEPTH=16, sink_ready=0, 17 back-to-back sample_valid pulses -> 16 stored, overflow=1, the 17th sample never appears on sink_real.
REQ-039 Reset pulse after 500 transfers -> outputs 0 during reset; the next frame's sop carries the first post-reset sample.
REQ-040 Model asserts source_error=2'b01 on one beat -> fft_error=1 and stays 1; frame_done is still issued.
REQ-041 Model emits source_eop after 1000 beats -> fft_error=1, FSM returns to IDLE, and the next frame proceeds normally.
